div_unit: RTL and testbench

Iterative radix-2 integer divider serving the divide reservation station and writing its result to the CDB. Accepts one DIV/DIVU/REM/REMU operation per issue while idle, holds `running` high until the result leaves, and discards in-flight work killed by a branch flush. Sits between the divide reservation station (issue side) and the CDB arbiter (result side).

---
 rtl/rv32i_types.sv | 40 ++++
 rtl/div_unit_if.sv | 42 ++++
 rtl/div_step_m.sv | 30 +++
 rtl/div_unit.sv | 135 +++++++++++++
 tb/tb_div_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types
// Description : Shared types for the out-of-order core: branch tags, divider
//               state encoding, div_op bit positions and the tag kill rule.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

  localparam int BR_TAG_WIDTH = 4;

  typedef struct packed {
    logic                    sign;
    logic [BR_TAG_WIDTH-1:0] tag;
  } branch_tag_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int DIV_OP_REM    = 0;
  localparam int DIV_OP_SIGNED = 1;

  localparam logic [31:0] C_INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] C_ALL_ONES = 32'hFFFF_FFFF;

  // A held tag dies when it is younger than (depends on) the mispredicted branch.
  function automatic logic br_tag_killed(input branch_tag_t tag, input branch_tag_t flush_tag);
    if (tag.sign == flush_tag.sign)
      return (tag.tag & flush_tag.tag) == flush_tag.tag;
    else
      return (tag.tag & flush_tag.tag) == tag.tag;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_unit_if.sv
// ============================================================================
// Module      : div_unit_if
// Description : Issue-side and CDB-side bundle of the divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_unit_if #(
  parameter int ROB_WIDTH = 3
);
  import rv32i_types::*;

  logic                 flush;
  branch_tag_t          flush_tag;
  logic                 issue;
  logic [31:0]          operand1;
  logic [31:0]          operand2;
  branch_tag_t          br_tag_in;
  logic [ROB_WIDTH-1:0] dest_ROB_in;
  logic [1:0]           div_op;
  logic                 running;
  logic                 result_valid;
  logic                 result_ready;
  logic [31:0]          result_data;
  logic [ROB_WIDTH-1:0] result_rob;
  branch_tag_t          result_br_tag;

  modport master (
    output flush, flush_tag, issue, operand1, operand2, br_tag_in, dest_ROB_in,
           div_op, result_ready,
    input  running, result_valid, result_data, result_rob, result_br_tag
  );

  modport slave (
    input  flush, flush_tag, issue, operand1, operand2, br_tag_in, dest_ROB_in,
           div_op, result_ready,
    output running, result_valid, result_data, result_rob, result_br_tag
  );

endinterface

`default_nettype wire

// File: rtl/div_step_m.sv
// ============================================================================
// Module      : div_step_m
// Description : One combinational restoring-division step; the quotient
//               register doubles as the dividend shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step_m (
  input  logic [32:0] rem_in,
  input  logic [31:0] divisor,
  input  logic [31:0] quo_in,
  output logic [32:0] rem_out,
  output logic [31:0] quo_out
);

  logic [32:0] w_shifted;
  logic [32:0] w_diff;
  logic        w_unused_rem_msb;

  // A restored remainder is always below the divisor, so its bit 32 is zero.
  assign w_unused_rem_msb = rem_in[32];
  assign w_shifted        = {rem_in[31:0], quo_in[31]};
  assign w_diff           = w_shifted - {1'b0, divisor};
  assign rem_out          = w_diff[32] ? w_shifted : w_diff;
  assign quo_out          = {quo_in[30:0], ~w_diff[32]};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module      : div_unit
// Description : Iterative radix-2 DIV/DIVU/REM/REMU unit between the divide
//               reservation station and the CDB arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
  import rv32i_types::*;
#(
  parameter int ROB_WIDTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  div_state_t           r_state;
  div_state_t           w_next_state;
  logic [ROB_WIDTH-1:0] r_rob;
  branch_tag_t          r_tag;
  logic                 r_rem_sel;
  logic                 r_q_neg;
  logic                 r_r_neg;
  logic [32:0]          r_rem;
  logic [31:0]          r_quo;
  logic [31:0]          r_dvsr;
  logic [4:0]           r_cnt;
  logic [31:0]          r_result;

  logic        w_signed, w_dvd_neg, w_dvs_neg;
  logic [31:0] w_abs_dvd, w_abs_dvs;
  logic        w_div_zero, w_overflow;
  logic [31:0] w_special_result;
  logic        w_issue_ok, w_held_killed, w_valid;
  logic [32:0] w_rem_next;
  logic [31:0] w_quo_next, w_q_fix, w_r_fix, w_final;

  assign w_signed   = bus.div_op[DIV_OP_SIGNED];
  assign w_dvd_neg  = w_signed & bus.operand1[31];
  assign w_dvs_neg  = w_signed & bus.operand2[31];
  assign w_abs_dvd  = w_dvd_neg ? -bus.operand1 : bus.operand1;
  assign w_abs_dvs  = w_dvs_neg ? -bus.operand2 : bus.operand2;
  assign w_div_zero = (bus.operand2 == '0);
  assign w_overflow = w_signed && (bus.operand1 == C_INT_MIN) && (bus.operand2 == C_ALL_ONES);

  always_comb begin
    w_special_result = '0;
    if (w_div_zero)
      w_special_result = bus.div_op[DIV_OP_REM] ? bus.operand1 : C_ALL_ONES;
    else if (w_overflow)
      w_special_result = bus.div_op[DIV_OP_REM] ? 32'd0 : C_INT_MIN;
  end

  assign w_issue_ok    = bus.issue && !(bus.flush && br_tag_killed(bus.br_tag_in, bus.flush_tag));
  assign w_held_killed = bus.flush && br_tag_killed(r_tag, bus.flush_tag);
  // The flush cycle masks the offer so a dying result can never be granted.
  assign w_valid       = (r_state == DIV_DONE) && !w_held_killed;

  div_step_m u_step (
    .rem_in  (r_rem),
    .divisor (r_dvsr),
    .quo_in  (r_quo),
    .rem_out (w_rem_next),
    .quo_out (w_quo_next)
  );

  assign w_q_fix = r_q_neg ? -w_quo_next : w_quo_next;
  assign w_r_fix = r_r_neg ? -w_rem_next[31:0] : w_rem_next[31:0];
  assign w_final = r_rem_sel ? w_r_fix : w_q_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DIV_IDLE: if (w_issue_ok) w_next_state = (w_div_zero || w_overflow) ? DIV_DONE : DIV_CALC;
      DIV_CALC: begin
        if (w_held_killed)        w_next_state = DIV_IDLE;
        else if (r_cnt == 5'd31)  w_next_state = DIV_DONE;
      end
      DIV_DONE: begin
        if (w_held_killed)                      w_next_state = DIV_IDLE;
        else if (w_valid && bus.result_ready)   w_next_state = DIV_IDLE;
      end
      default: w_next_state = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rob     <= '0;
      r_tag     <= '0;
      r_rem_sel <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
    end else begin
      if (r_state == DIV_IDLE && w_issue_ok) begin
        r_rob     <= bus.dest_ROB_in;
        r_tag     <= bus.br_tag_in;
        r_rem_sel <= bus.div_op[DIV_OP_REM];
        r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
        r_r_neg   <= w_dvd_neg;
        r_rem     <= '0;
        r_quo     <= w_abs_dvd;
        r_dvsr    <= w_abs_dvs;
        r_cnt     <= '0;
        if (w_div_zero || w_overflow) r_result <= w_special_result;
      end else if (r_state == DIV_CALC) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) r_result <= w_final;
      end
    end
  end

  assign bus.running       = (r_state != DIV_IDLE);
  assign bus.result_valid  = w_valid;
  assign bus.result_data   = r_result;
  assign bus.result_rob    = r_rob;
  assign bus.result_br_tag = r_tag;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module      : tb_div_unit
// Description : Scoreboard bench for div_unit with directed and random ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;
  import rv32i_types::*;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  rob;
    branch_tag_t tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ready_fixed;
  logic ready_rand;
  bit   rand_ready;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  div_unit_if #(.ROB_WIDTH(3)) bus ();

  div_unit #(.ROB_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.result_ready = rand_ready ? ready_rand : ready_fixed;

  always @(posedge clk) begin
    #1;
    ready_rand = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic branch_tag_t mk_tag(input logic s, input logic [3:0] t);
    branch_tag_t r;
    r.sign = s;
    r.tag  = t;
    return r;
  endfunction

  // Reference: RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (op[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
    return op[0] ? r : q;
  endfunction

  // Monitor: pops one expectation per CDB handshake.
  always @(negedge clk) begin
    if (!rst && bus.result_valid && bus.result_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got data 0x%08h, expected no result", bus.result_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_data", bus.result_data, e.data);
        check("result_rob", {29'b0, bus.result_rob}, {29'b0, e.rob});
        check("result_br_tag", {27'b0, bus.result_br_tag}, {27'b0, e.tag});
      end
    end
    if (bus.issue && bus.running) begin
      n_checks++;
      $display("FAIL issue_while_running: got issue=1 running=1, expected no issue");
    end
  end

  task automatic issue_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic [2:0] rob, input branch_tag_t tag, input bit expect_result);
    exp_t e;
    bus.issue = 1'b1; bus.operand1 = a; bus.operand2 = b; bus.div_op = op;
    bus.dest_ROB_in = rob; bus.br_tag_in = tag;
    @(posedge clk); #1;
    bus.issue = 1'b0;
    if (expect_result) begin
      e.data = ref_div(a, b, op); e.rob = rob; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic wait_valid(input string name, input int exp_lat, input int start);
    int lat = start;
    while (!bus.result_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    check(name, 32'(lat), 32'(exp_lat));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.running && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check(name, {31'b0, bus.running}, 32'd0);
  endtask

  task automatic flush_case(input string name, input branch_tag_t tag, input branch_tag_t ftag, input bit killed);
    int seen = 0;
    issue_op(32'd12345, 32'd17, 2'b01, 3'd6, tag, !killed);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1; bus.flush_tag = ftag;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    if (killed) begin
      check({name, "_idle"}, {31'b0, bus.running}, 32'd0);
      repeat (40) begin
        if (bus.result_valid) seen++;
        @(posedge clk); #1;
      end
      check({name, "_no_valid"}, 32'(seen), 32'd0);
    end else begin
      wait_valid({name, "_lat"}, 33, 11);
      wait_idle({name, "_idle"});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic [1:0]  op;
    logic [4:0]  tg;
    bit          special;

    rst = 1'b1; ready_fixed = 1'b0; rand_ready = 1'b0;
    bus.issue = 1'b0; bus.flush = 1'b0; bus.flush_tag = '0; bus.operand1 = '0;
    bus.operand2 = '0; bus.div_op = '0; bus.dest_ROB_in = '0; bus.br_tag_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_running", {31'b0, bus.running}, 32'd0);
    check("rst_valid", {31'b0, bus.result_valid}, 32'd0);
    check("rst_data", bus.result_data, 32'd0);
    check("rst_rob", {29'b0, bus.result_rob}, 32'd0);
    check("rst_tag", {27'b0, bus.result_br_tag}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    ready_fixed = 1'b1;

    // Directed quotient/remainder cases and the two special cases.
    issue_op(32'd100, 32'd7, 2'b00, 3'd1, mk_tag(1'b0, 4'b0001), 1); wait_valid("lat_divu", 33, 1); wait_idle("idle_divu");
    issue_op(32'd100, 32'd7, 2'b01, 3'd2, mk_tag(1'b0, 4'b0010), 1); wait_valid("lat_remu", 33, 1); wait_idle("idle_remu");
    issue_op(32'hFFFF_FF9C, 32'd7, 2'b10, 3'd3, mk_tag(1'b1, 4'b0001), 1); wait_valid("lat_div", 33, 1); wait_idle("idle_div");
    issue_op(32'hFFFF_FF9C, 32'd7, 2'b11, 3'd4, mk_tag(1'b1, 4'b0100), 1); wait_valid("lat_rem", 33, 1); wait_idle("idle_rem");
    issue_op(32'd5, 32'd0, 2'b00, 3'd5, mk_tag(1'b0, 4'b1000), 1); wait_valid("lat_dz_q", 1, 1); wait_idle("idle_dz_q");
    issue_op(32'd5, 32'd0, 2'b01, 3'd6, mk_tag(1'b0, 4'b1000), 1); wait_valid("lat_dz_r", 1, 1); wait_idle("idle_dz_r");
    issue_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 3'd7, mk_tag(1'b1, 4'b0011), 1); wait_valid("lat_ovf_q", 1, 1); wait_idle("idle_ovf_q");
    issue_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 3'd0, mk_tag(1'b1, 4'b0011), 1); wait_valid("lat_ovf_r", 1, 1); wait_idle("idle_ovf_r");

    // CDB back-pressure, then back-to-back issue in the first idle cycle.
    ready_fixed = 1'b0;
    issue_op(32'd1000, 32'd3, 2'b00, 3'd5, mk_tag(1'b0, 4'b0101), 1);
    wait_valid("lat_stall", 33, 1);
    repeat (10) begin
      check("stall_valid", {31'b0, bus.result_valid}, 32'd1);
      check("stall_data", bus.result_data, 32'd333);
      check("stall_running", {31'b0, bus.running}, 32'd1);
      @(posedge clk); #1;
    end
    ready_fixed = 1'b1;
    check("grant_cycle_running", {31'b0, bus.running}, 32'd1);
    @(posedge clk); #1;
    check("after_grant_running", {31'b0, bus.running}, 32'd0);
    issue_op(32'd77, 32'hFFFF_FFF9, 2'b10, 3'd2, mk_tag(1'b0, 4'b0110), 1);
    wait_valid("lat_b2b", 33, 1); wait_idle("idle_b2b");

    // Flush during CALC: same-sign and opposite-sign tags, killed and spared.
    flush_case("fl_same_kill", mk_tag(1'b0, 4'b0011), mk_tag(1'b0, 4'b0001), 1);
    flush_case("fl_same_keep", mk_tag(1'b0, 4'b0011), mk_tag(1'b0, 4'b0100), 0);
    flush_case("fl_diff_kill", mk_tag(1'b1, 4'b0011), mk_tag(1'b0, 4'b0111), 1);
    flush_case("fl_diff_keep", mk_tag(1'b1, 4'b0011), mk_tag(1'b0, 4'b0001), 0);

    // Flush in IDLE blocks capture of a killed issue.
    bus.flush = 1'b1; bus.flush_tag = mk_tag(1'b0, 4'b0001);
    issue_op(32'd9, 32'd2, 2'b00, 3'd1, mk_tag(1'b0, 4'b0011), 0);
    bus.flush = 1'b0;
    check("idle_flush_no_capture", {31'b0, bus.running}, 32'd0);

    // Flush in DONE coinciding with the grant drops the result.
    ready_fixed = 1'b0;
    issue_op(32'd999, 32'd10, 2'b00, 3'd2, mk_tag(1'b0, 4'b0110), 0);
    wait_valid("lat_done_kill", 33, 1);
    bus.flush = 1'b1; bus.flush_tag = mk_tag(1'b0, 4'b0010);
    ready_fixed = 1'b1;
    #1;
    check("done_kill_valid_masked", {31'b0, bus.result_valid}, 32'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("done_kill_idle", {31'b0, bus.running}, 32'd0);

    // Asynchronous reset in the middle of CALC.
    issue_op(32'd5000, 32'd3, 2'b00, 3'd3, mk_tag(1'b0, 4'b0101), 0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_running", {31'b0, bus.running}, 32'd0);
    check("arst_valid", {31'b0, bus.result_valid}, 32'd0);
    check("arst_data", bus.result_data, 32'd0);
    check("arst_rob", {29'b0, bus.result_rob}, 32'd0);
    check("arst_tag", {27'b0, bus.result_br_tag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Random operations with random CDB grants.
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      tg = 5'($urandom);
      special = (b == 32'd0) || (op[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      issue_op(a, b, op, 3'($urandom), branch_tag_t'(tg), 1);
      wait_valid("lat_rand", special ? 1 : 33, 1);
      wait_idle("idle_rand");
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
